// File: rtl/keyboard_controls.sv
// PS/2 scan-code set 2 receiver with make/break tracking for the arrow keys.
// Define KEYBOARD_WASD_EN to also decode W/A/S/D onto the same four outputs.
module keyboard_controls #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       turn_right,
  output logic       turn_left,
  output logic       move_forward,
  output logic       move_backward,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  typedef struct packed {
    logic right;
    logic left;
    logic forward;
    logic backward;
  } keys_t;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
`ifdef KEYBOARD_WASD_EN
  localparam logic [7:0] CODE_W     = 8'h1D;
  localparam logic [7:0] CODE_A     = 8'h1C;
  localparam logic [7:0] CODE_S     = 8'h1B;
  localparam logic [7:0] CODE_D     = 8'h23;
`endif
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // Synchronisers and falling-edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_prev;
  logic       fall_edge;
  logic       bit_in;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  // Lines idle high, so the flops reset to 1 to avoid a false edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall_edge = clk_prev & ~clk_sync[1];
  assign bit_in    = dat_sync[1];

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_t            state, state_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic [7:0]           shift, shift_n;
  logic                 parity_ok, parity_ok_n;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 timeout_hit;
  logic                 good_n;
  logic                 err_n;

  assign timeout_hit = (state != S_IDLE) && (timeout_cnt == TIMEOUT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      parity_ok <= parity_ok_n;
    end
  end

  // NOTE: every variable driven here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    parity_ok_n = parity_ok;
    good_n      = 1'b0;
    err_n       = 1'b0;

    if (fall_edge) begin
      unique case (state)
        S_IDLE: begin
          if (!bit_in) begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
        S_DATA: begin
          shift_n   = {bit_in, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_PARITY;
        end
        S_PARITY: begin
          parity_ok_n = ^{shift, bit_in};
          state_n     = S_STOP;
        end
        S_STOP: begin
          state_n = S_IDLE;
          if (bit_in && parity_ok) good_n = 1'b1;
          else                     err_n  = 1'b1;
        end
      endcase
    end else if (timeout_hit) begin
      // A stalled keyboard must not leave a half-built byte waiting forever.
      state_n = S_IDLE;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_cnt <= '0;
    end else if (fall_edge || state == S_IDLE || timeout_hit) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= good_n;
      frame_error <= err_n;
      if (good_n) byte_data <= shift;
    end
  end

  // ---------------------------------------------------------------------------
  // Make/break decoder
  // ---------------------------------------------------------------------------
  logic  ext;
  logic  brk;
  keys_t arrow_keys;
  keys_t key_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      arrow_keys <= '0;
    end else if (frame_error) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == CODE_EXT) begin
        ext <= 1'b1;
      end else if (byte_data == CODE_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (ext) begin
          case (byte_data)
            CODE_RIGHT: arrow_keys.right    <= ~brk;
            CODE_LEFT:  arrow_keys.left     <= ~brk;
            CODE_UP:    arrow_keys.forward  <= ~brk;
            CODE_DOWN:  arrow_keys.backward <= ~brk;
            default:    ;
          endcase
        end
      end
    end
  end

`ifdef KEYBOARD_WASD_EN
  keys_t letter_keys;

  // Letters are tracked apart from arrows so releasing one never drops the other.
  always_ff @(posedge clock) begin
    if (reset) begin
      letter_keys <= '0;
    end else if (byte_valid && !ext &&
                 byte_data != CODE_EXT && byte_data != CODE_BRK) begin
      case (byte_data)
        CODE_D:  letter_keys.right    <= ~brk;
        CODE_A:  letter_keys.left     <= ~brk;
        CODE_W:  letter_keys.forward  <= ~brk;
        CODE_S:  letter_keys.backward <= ~brk;
        default: ;
      endcase
    end
  end

  assign key_out = keys_t'(arrow_keys | letter_keys);
`else
  assign key_out = arrow_keys;
`endif

  assign turn_right    = key_out.right;
  assign turn_left     = key_out.left;
  assign move_forward  = key_out.forward;
  assign move_backward = key_out.backward;

endmodule

// File: tb/tb_keyboard_controls.sv
// Randomised PS/2 frame bench for keyboard_controls with a make/break key model.
// Honours KEYBOARD_WASD_EN the same way as the design.
module tb_keyboard_controls;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       turn_right, turn_left, move_forward, move_backward;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_error;

  keyboard_controls #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .TIMEOUT_W     (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .turn_right   (turn_right),
    .turn_left    (turn_left),
    .move_forward (move_forward),
    .move_backward(move_backward),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .frame_error  (frame_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: key bits ordered {right, left, forward, backward}.
  bit       m_ext, m_brk;
  bit [3:0] m_arrow, m_letter;
  logic [7:0] last_good = 8'h00;

  function automatic int arrow_slot(input logic [7:0] code);
    case (code)
      8'h74:   return 3;
      8'h6B:   return 2;
      8'h75:   return 1;
      8'h72:   return 0;
      default: return -1;
    endcase
  endfunction

`ifdef KEYBOARD_WASD_EN
  function automatic int letter_slot(input logic [7:0] code);
    case (code)
      8'h23:   return 3;
      8'h1C:   return 2;
      8'h1D:   return 1;
      8'h1B:   return 0;
      default: return -1;
    endcase
  endfunction
`endif

  function automatic logic [3:0] model_keys();
    return m_arrow | m_letter;
  endfunction

  task automatic model_good(input logic [7:0] b);
    int s;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      s = arrow_slot(b);
      if (m_ext && s >= 0) m_arrow[s] = !m_brk;
`ifdef KEYBOARD_WASD_EN
      s = letter_slot(b);
      if (!m_ext && s >= 0) m_letter[s] = !m_brk;
`endif
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Monitor: counts pulses and checks the one-cycle key update latency.
  int         cyc = 0;
  int         bv_count = 0;
  int         fe_count = 0;
  int         fe_cyc = 0;
  int         last_fall_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic [3:0] pre_keys = 4'h0;
  logic [3:0] exp_keys = 4'h0;
  logic       bv_prev = 1'b0;
  wire  [3:0] dut_keys = {turn_right, turn_left, move_forward, move_backward};

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (bv_prev) check("key_latency", dut_keys, exp_keys);
    if (byte_valid === 1'b1) begin
      bv_count++;
      last_data = byte_data;
      check("key_before_update", dut_keys, pre_keys);
    end
    if (frame_error === 1'b1) begin
      fe_count++;
      fe_cyc = cyc;
    end
    bv_prev = (byte_valid === 1'b1);
  end

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  // fault: 0 none, 1 bad parity, 2 bad stop bit
  task automatic send_frame(input logic [7:0] b, input int fault);
    logic par;
    int   bv0, fe0;
    bit   good;
    good     = (fault == 0);
    pre_keys = model_keys();
    if (good) model_good(b);
    else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    exp_keys = model_keys();
    bv0 = bv_count;
    fe0 = fe_count;
    par = ~^b;
    if (fault == 1) par = ~par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(fault == 2 ? 1'b0 : 1'b1);
    ps2_dat = 1'b1;
    repeat (4) @(negedge clock);
    check("byte_valid_count", bv_count - bv0, good ? 1 : 0);
    check("frame_error_count", fe_count - fe0, good ? 0 : 1);
    if (good) begin
      check("byte_data", last_data, b);
      last_good = b;
    end
    check("byte_data_held", byte_data, last_good);
    check("keys", dut_keys, exp_keys);
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    send_frame(a, 0);
    send_frame(b, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, pick, fault;
    logic [7:0] code;
    logic [7:0] pool [10] = '{8'hE0, 8'hE0, 8'hF0, 8'h74, 8'h6B, 8'h75, 8'h72,
                              8'h1D, 8'h1C, 8'h23};

    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_keys", dut_keys, 4'h0);
    check("reset_byte_valid", byte_valid, 1'b0);
    check("reset_byte_data", byte_data, 8'h00);
    check("reset_frame_error", frame_error, 1'b0);

    // Make, break, and two arrows held together.
    send_pair(8'hE0, 8'h75);
    check("up_make", move_forward, 1'b1);
    send_frame(8'hE0, 0); send_pair(8'hF0, 8'h75);
    check("up_break", move_forward, 1'b0);
    send_pair(8'hE0, 8'h74);
    send_pair(8'hE0, 8'h6B);
    check("right_and_left", {turn_right, turn_left}, 2'b11);
    send_pair(8'hE0, 8'h6B);  // typematic repeat

    // Bad parity, then a good down-arrow.
    send_frame(8'h75, 1);
    send_pair(8'hE0, 8'h72);
    check("down_after_parity_err", move_backward, 1'b1);

    // Stray start bit of 1 is an error and drops a pending E0.
    send_frame(8'hE0, 0);
    pre_keys = model_keys(); m_ext = 0; m_brk = 0; exp_keys = model_keys();
    fe0 = fe_count;
    ps2_bit(1'b1);
    repeat (4) @(negedge clock);
    check("start_bit_error", fe_count - fe0, 1);
    send_frame(8'h75, 0);
    check("ext_cleared_by_error", move_forward, 1'b0);

    // Timeout after five data bits.
    pre_keys = model_keys(); m_ext = 0; m_brk = 0; exp_keys = model_keys();
    fe0 = fe_count;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    for (int i = 0; i < TIMEOUT + 100 && fe_count == fe0; i++) @(negedge clock);
    repeat (20) @(negedge clock);
    check("timeout_pulse", fe_count - fe0, 1);
    check("timeout_latency_ok",
          (fe_cyc - last_fall_cyc >= TIMEOUT) && (fe_cyc - last_fall_cyc <= TIMEOUT + 6), 1);
    check("keys_after_timeout", dut_keys, exp_keys);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h6B, 0);
    send_pair(8'hE0, 8'h6B);
    check("left_after_timeout", turn_left, 1'b1);

    // Bare keypad code has no effect on the arrows.
    send_frame(8'h75, 0);
    send_frame(8'h72, 2);

`ifdef KEYBOARD_WASD_EN
    send_frame(8'h1D, 0);
    check("w_make", move_forward, 1'b1);
    send_pair(8'hE0, 8'h75);
    send_frame(8'hE0, 0); send_pair(8'hF0, 8'h75);
    check("w_survives_up_break", move_forward, 1'b1);
    send_pair(8'hF0, 8'h1D);
    check("w_break", move_forward, 1'b0);
`endif

    // Randomised traffic.
    for (int n = 0; n < 70; n++) begin
      pick = $urandom_range(0, 10);
      code = (pick == 10) ? 8'($urandom) : pool[pick];
      fault = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      send_frame(code, fault);
    end

    // Reset mid-frame with forward held.
    send_pair(8'hE0, 8'h75);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midframe_reset_keys", dut_keys, 4'h0);
    check("midframe_reset_byte_data", byte_data, 8'h00);
    check("midframe_reset_byte_valid", byte_valid, 1'b0);
    m_ext = 0; m_brk = 0; m_arrow = '0; m_letter = '0; last_good = 8'h00;
    repeat (4) @(negedge clock);
    send_pair(8'hE0, 8'h74);
    check("right_after_reset", turn_right, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
